// File: rtl/diffusion_pipe.sv
// Diffusion cell update: u_next = u + (alpha/2)*(avg(nbr) - u), frozen = (u_next + v) >= 1.0.
// Four register stages, result on out_* four cycles after acceptance; one transaction per cycle.
// Whole pipe stalls while out_valid & ~out_ready; in_ready = out_ready | ~out_valid. Saturation: `DIFF_SAT_EN.
module diffusion_pipe #(
  parameter int WIDTH = 18,
  parameter int FRAC  = 16,
  parameter int NBR   = 6,
  parameter int IDXW  = 16,
  parameter int CNTW  = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NBR*WIDTH-1:0]  in_nbr,
  input  logic [WIDTH-1:0]      in_u,
  input  logic [WIDTH-1:0]      in_v,
  input  logic [WIDTH-1:0]      in_alpha,
  input  logic [IDXW-1:0]       in_idx,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_u,
  output logic                  out_frozen,
  output logic                  out_sat,
  output logic [IDXW-1:0]       out_idx,
  input  logic                  cnt_clr,
  output logic [CNTW-1:0]       frozen_cnt
);

  localparam int SW    = WIDTH + $clog2(NBR);
  localparam int PW2   = SW + WIDTH;
  localparam int PW3   = 2 * WIDTH + 1;
  localparam int RECIP = (1 << FRAC) / NBR;
  localparam logic signed [WIDTH-1:0] RECIP_W = WIDTH'(RECIP);
  localparam logic signed [WIDTH:0]   ONE_FX  = (WIDTH+1)'(1 << FRAC);
  localparam logic [CNTW-1:0]         CNT_MAX = '1;
`ifdef DIFF_SAT_EN
  localparam logic signed [WIDTH+1:0] RAW_MAX = (WIDTH+2)'((1 << (WIDTH-1)) - 1);
  localparam logic signed [WIDTH+1:0] RAW_MIN = (WIDTH+2)'(-(1 << (WIDTH-1)));
`endif

  logic adv;
  logic s1_vld, s2_vld, s3_vld;
  logic signed [SW-1:0]    nbr_sum, s1_sum;
  logic signed [WIDTH-1:0] s1_u, s1_v, s1_alpha;
  logic signed [WIDTH-1:0] s2_avg, s2_u, s2_v, s2_alpha;
  logic signed [WIDTH-1:0] s3_u, s3_v;
  logic signed [WIDTH:0]   s3_lap;
  logic [IDXW-1:0]         s1_idx, s2_idx, s3_idx;

  logic signed [PW2-1:0]   avg_prod;
  logic signed [WIDTH-1:0] avg_nxt;
  logic signed [WIDTH:0]   diff;
  logic signed [WIDTH-1:0] alpha_half;
  logic signed [PW3-1:0]   lap_prod;
  logic signed [WIDTH:0]   lap_nxt;
  logic signed [WIDTH+1:0] raw;
  logic signed [WIDTH-1:0] u_nxt;
  logic                    sat_nxt;
  logic signed [WIDTH:0]   frz_sum;
  logic                    frz_nxt;

  // The whole pipe moves as one when the output slot is free or being drained.
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  // S1 input: neighbour sum, widened so it can never overflow.
  always_comb begin
    nbr_sum = '0;
    for (int k = 0; k < NBR; k++) begin
      nbr_sum = nbr_sum + SW'($signed(in_nbr[k*WIDTH +: WIDTH]));
    end
  end

  // S2 input: average via reciprocal multiply, floor-rescaled then truncated.
  always_comb begin
    avg_prod = PW2'(s1_sum) * PW2'(RECIP_W);
    avg_nxt  = WIDTH'(avg_prod >>> FRAC);
  end

  // S3 input: Laplacian term (alpha/2)*(avg - u).
  always_comb begin
    diff       = (WIDTH+1)'(s2_avg) - (WIDTH+1)'(s2_u);
    alpha_half = s2_alpha >>> 1;
    lap_prod   = PW3'(alpha_half) * PW3'(diff);
    lap_nxt    = (WIDTH+1)'(lap_prod >>> FRAC);
  end

  // S4 input: update, resize (clamp or wrap) and frozen test on the final value.
  always_comb begin
    raw     = (WIDTH+2)'(s3_u) + (WIDTH+2)'(s3_lap);
    u_nxt   = WIDTH'(raw);
    sat_nxt = 1'b0;
`ifdef DIFF_SAT_EN
    if (raw > RAW_MAX) begin
      u_nxt   = WIDTH'(RAW_MAX);
      sat_nxt = 1'b1;
    end else if (raw < RAW_MIN) begin
      u_nxt   = WIDTH'(RAW_MIN);
      sat_nxt = 1'b1;
    end
`endif
    frz_sum = (WIDTH+1)'(u_nxt) + (WIDTH+1)'(s3_v);
    frz_nxt = (frz_sum >= ONE_FX);
  end

  // Stage valids and output registers: cleared by reset, advance together.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld     <= 1'b0;
      s2_vld     <= 1'b0;
      s3_vld     <= 1'b0;
      out_valid  <= 1'b0;
      out_u      <= '0;
      out_frozen <= 1'b0;
      out_sat    <= 1'b0;
      out_idx    <= '0;
    end else if (adv) begin
      s1_vld     <= in_valid;
      s2_vld     <= s1_vld;
      s3_vld     <= s2_vld;
      out_valid  <= s3_vld;
      out_u      <= u_nxt;
      out_frozen <= frz_nxt;
      out_sat    <= sat_nxt;
      out_idx    <= s3_idx;
    end
  end

  // Intermediate datapath registers; contents are only meaningful under their valid.
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_sum   <= nbr_sum;
      s1_u     <= in_u;
      s1_v     <= in_v;
      s1_alpha <= in_alpha;
      s1_idx   <= in_idx;
      s2_avg   <= avg_nxt;
      s2_u     <= s1_u;
      s2_v     <= s1_v;
      s2_alpha <= s1_alpha;
      s2_idx   <= s1_idx;
      s3_lap   <= lap_nxt;
      s3_u     <= s2_u;
      s3_v     <= s2_v;
      s3_idx   <= s2_idx;
    end
  end

  // Frozen-result counter: saturating, clear has priority over increment.
  always_ff @(posedge clk) begin
    if (reset || cnt_clr) begin
      frozen_cnt <= '0;
    end else if (out_valid && out_ready && out_frozen && (frozen_cnt != CNT_MAX)) begin
      frozen_cnt <= frozen_cnt + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_diffusion_pipe.sv
// Self-checking bench for diffusion_pipe: directed corner cases plus randomized traffic
// compared each cycle against an arithmetic reference model with a 4-slot pipe model.
// Counter width is reduced to 2 bits so saturation is reachable.
module tb_diffusion_pipe;
  localparam int W  = 18;
  localparam int F  = 16;
  localparam int N  = 6;
  localparam int IW = 16;
  localparam int CW = 2;
  localparam longint RECIP   = (64'sd1 <<< F) / N;
  localparam int     CNT_TOP = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset, in_valid, in_ready, out_valid, out_ready, out_frozen, out_sat, cnt_clr;
  logic [N*W-1:0] in_nbr;
  logic [W-1:0]   in_u, in_v, in_alpha, out_u;
  logic [IW-1:0]  in_idx, out_idx;
  logic [CW-1:0]  frozen_cnt;

  always #5 clk = ~clk;

  diffusion_pipe #(.WIDTH(W), .FRAC(F), .NBR(N), .IDXW(IW), .CNTW(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_nbr(in_nbr), .in_u(in_u), .in_v(in_v), .in_alpha(in_alpha), .in_idx(in_idx),
    .out_valid(out_valid), .out_ready(out_ready), .out_u(out_u), .out_frozen(out_frozen),
    .out_sat(out_sat), .out_idx(out_idx), .cnt_clr(cnt_clr), .frozen_cnt(frozen_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Pipe model: slot 3 is what must be on out_*.
  logic          mv [4];
  logic [W-1:0]  mu [4];
  logic          mf [4];
  logic          ms [4];
  logic [IW-1:0] mi [4];
  int            mcnt = 0;
  logic          accepted;
  logic [IW-1:0] out_log [$];
  logic          pstall = 1'b0;
  logic [W-1:0]  pu;
  logic [IW-1:0] pidx;
  logic          pf, ps;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic longint wrapw(input longint x, input int w);
    longint m;
    m = x & ((64'sd1 <<< w) - 1);
    if (m >= (64'sd1 <<< (w - 1))) m = m - (64'sd1 <<< w);
    return m;
  endfunction

  function automatic longint sx(input logic [W-1:0] x);
    return longint'($signed(x));
  endfunction

  // Reference arithmetic straight from the cell-update rules.
  task automatic calc(input logic [N*W-1:0] nb, input logic [W-1:0] u, v, a,
                      output logic [W-1:0] ou, output logic of, output logic os);
    longint sum, avg, d, lap, raw, uo;
    logic [W-1:0] t;
    sum = 0;
    for (int k = 0; k < N; k++) begin
      t = nb[k*W +: W];
      sum += sx(t);
    end
    avg = wrapw((sum * RECIP) >>> F, W);
    d   = avg - sx(u);
    lap = wrapw(((sx(a) >>> 1) * d) >>> F, W + 1);
    raw = sx(u) + lap;
    os  = 1'b0;
`ifdef DIFF_SAT_EN
    uo = raw;
    if (raw > (64'sd1 <<< (W - 1)) - 1) begin uo = (64'sd1 <<< (W - 1)) - 1; os = 1'b1; end
    else if (raw < -(64'sd1 <<< (W - 1))) begin uo = -(64'sd1 <<< (W - 1)); os = 1'b1; end
`else
    uo = wrapw(raw, W);
`endif
    of = ((uo + sx(v)) >= (64'sd1 <<< F));
    ou = W'(uo);
  endtask

  // One clock: compare at negedge+1, advance the model for the coming posedge.
  task automatic step();
    logic [W-1:0] tu;
    logic tf, ts;
    #1;
    chk("out_valid", out_valid, mv[3]);
    if (mv[3]) begin
      chk("out_u", out_u, mu[3]);
      chk("out_frozen", out_frozen, mf[3]);
      chk("out_sat", out_sat, ms[3]);
      chk("out_idx", out_idx, mi[3]);
    end
    chk("in_ready", in_ready, out_ready | !mv[3]);
    chk("frozen_cnt", frozen_cnt, mcnt);
    if (pstall) begin
      chk("hold_u", out_u, pu);
      chk("hold_idx", out_idx, pidx);
      chk("hold_flags", {out_frozen, out_sat}, {pf, ps});
    end
    pstall   = out_valid && !out_ready && !reset;
    pu       = out_u;
    pidx     = out_idx;
    pf       = out_frozen;
    ps       = out_sat;
    accepted = in_valid && in_ready && !reset;
    if (reset) begin
      for (int i = 0; i < 4; i++) mv[i] = 1'b0;
      mcnt = 0;
    end else begin
      if (mv[3] && out_ready) begin
        out_log.push_back(mi[3]);
        if (mf[3] && mcnt < CNT_TOP) mcnt++;
      end
      if (cnt_clr) mcnt = 0;
      if (out_ready || !mv[3]) begin
        for (int i = 3; i > 0; i--) begin
          mv[i] = mv[i-1]; mu[i] = mu[i-1]; mf[i] = mf[i-1]; ms[i] = ms[i-1]; mi[i] = mi[i-1];
        end
        calc(in_nbr, in_u, in_v, in_alpha, tu, tf, ts);
        mv[0] = in_valid; mu[0] = tu; mf[0] = tf; ms[0] = ts; mi[0] = in_idx;
      end
    end
    @(negedge clk);
  endtask

  task automatic set_nbr(input logic [W-1:0] x);
    for (int k = 0; k < N; k++) in_nbr[k*W +: W] = x;
  endtask

  task automatic send(input logic [W-1:0] nb, u, v, a, input logic [IW-1:0] idx);
    set_nbr(nb); in_u = u; in_v = v; in_alpha = a; in_idx = idx;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string nm);
    int lat;
    lat = 1;
    while (!out_valid && lat < 12) begin
      step();
      lat++;
    end
    chk(nm, lat, 4);
  endtask

  logic [W-1:0] eu;
  logic ef, es;
  int sent, seen;

  initial begin
    for (int i = 0; i < 4; i++) mv[i] = 1'b0;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
    in_nbr = '0; in_u = '0; in_v = '0; in_alpha = '0; in_idx = '0;
    @(negedge clk);
    step(); step();
    reset = 1'b0;
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_u", out_u, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_flags", {out_frozen, out_sat}, 0);
    chk("rst_cnt", frozen_cnt, 0);
    chk("rst_in_ready", in_ready, 1);

    // Truncation
    set_nbr(W'('h04000));
    calc(in_nbr, W'('h04000), W'(0), W'('h10000), eu, ef, es);
    chk("model_trunc_u", eu, 'h03FFF);
    send(W'('h04000), W'('h04000), W'(0), W'('h10000), 16'h0011);
    wait_out("lat_trunc");
    chk("trunc_u", out_u, 'h03FFF);
    chk("trunc_frozen", out_frozen, 0);
    step();

    // Frozen boundary
    send(W'('h08000), W'('h08000), W'('h08000), W'('h10000), 16'h0021);
    wait_out("lat_frz0");
    chk("frz0_u", out_u, 'h07FFF);
    chk("frz0_frozen", out_frozen, 0);
    step();
    send(W'('h08000), W'('h08000), W'('h08001), W'('h10000), 16'h0022);
    wait_out("lat_frz1");
    chk("frz1_frozen", out_frozen, 1);
    step();
    chk("frz1_cnt", frozen_cnt, 1);

    // Overflow
    set_nbr(W'(0));
    calc(in_nbr, W'('h18000), W'(0), W'('h20000), eu, ef, es);
`ifdef DIFF_SAT_EN
    chk("model_ovf_u", eu, 'h1FFFF);
`else
    chk("model_ovf_u", eu, 'h30000);
`endif
    send(W'(0), W'('h18000), W'(0), W'('h20000), 16'h0031);
    wait_out("lat_ovf");
`ifdef DIFF_SAT_EN
    chk("ovf_u", out_u, 'h1FFFF);
    chk("ovf_sat", out_sat, 1);
`else
    chk("ovf_u", out_u, 'h30000);
    chk("ovf_sat", out_sat, 0);
`endif
    step();

    // Back-pressure: 6 tagged transactions, out_ready low cycles 3..10
    out_log.delete();
    sent = 0;
    for (int c = 0; c < 30; c++) begin
      out_ready = !(c >= 3 && c <= 10);
      in_valid  = (sent < 6);
      set_nbr(W'(c * 'h0800)); in_u = W'('h04000); in_v = W'('h0C000); in_alpha = W'('h10000);
      in_idx    = IW'(sent + 1);
      step();
      if (accepted) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_count", out_log.size(), 6);
    for (int i = 0; i < 6 && i < out_log.size(); i++) chk("bp_order", out_log[i], i + 1);

    // Counter saturation and clear priority
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    chk("clr_cnt", frozen_cnt, 0);
    for (int i = 0; i < 5; i++) send(W'('h08000), W'('h08000), W'('h08001), W'('h10000), IW'(i + 'h40));
    for (int i = 0; i < 6; i++) step();
    chk("sat_cnt", frozen_cnt, 3);
    send(W'('h08000), W'('h08000), W'('h08001), W'('h10000), 16'h0050);
    wait_out("lat_clr");
    chk("clr_hs_frozen", out_frozen, 1);
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    chk("clr_wins_cnt", frozen_cnt, 0);

    // Reset with three transactions in flight
    for (int i = 0; i < 3; i++) send(W'('h08000), W'('h08000), W'('h08001), W'('h10000), IW'(i + 'h60));
    reset = 1'b1; step(); reset = 1'b0;
    step();
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_cnt", frozen_cnt, 0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen++;
      step();
    end
    chk("mrst_no_output", seen, 0);

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 4) != 0;
      cnt_clr   = ($urandom % 32) == 0;
      for (int k = 0; k < N; k++)
        in_nbr[k*W +: W] = ($urandom % 2) ? W'($urandom) : W'($urandom_range(0, 'h14000));
      in_u     = ($urandom % 2) ? W'($urandom) : W'($urandom_range(0, 'h14000));
      in_v     = W'($urandom_range(0, 'h10000));
      in_alpha = ($urandom % 4) ? W'($urandom_range(0, 'h10000)) : W'($urandom);
      in_idx   = IW'($urandom);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
    for (int i = 0; i < 8; i++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
